// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//
// Latches a packed hex word (plus per-digit blank and decimal-point masks) into a pending
// buffer on load. The buffer is copied into the display registers only at the frame
// boundary, so a frame never tears. Each digit owns a slot of SCAN_DIV cycles. The first
// DEAD_CYCLES cycles of a slot keep all anodes off to avoid ghosting.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   value        packed nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   load         one-cycle strobe capturing value/blank/dp_in
//   blank        1 = digit i dark
//   dp_in        1 = decimal point i lit
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point of the active digit
//   an           digit enables, active-low
//   digit_idx    slot currently shown on the outputs
//   frame_start  one-cycle pulse when digit_idx wraps to 0
//
// Optional feature, enabled by defining SEG7_LEADING_ZERO_BLANK_EN: zero nibbles above the
// most significant nonzero digit are dark (digit 0 is never suppressed).

module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEAD_CYCLES    = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    // Active-low gfedcba encoding.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wrap_q;
    logic                    cnt_last, idx_last, boundary;

    logic [4*NUM_DIGITS-1:0] pend_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_dp_q, disp_blank_q, disp_dp_q;
    logic                    pend_valid_q;

    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              nib;
    logic                    blk, dpl, sup, dark, in_dead;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    always_comb begin
        cnt_last = (32'(cnt_q) == SCAN_DIV - 1);
        idx_last = (32'(idx_q) == NUM_DIGITS - 1);
        boundary = cnt_last && idx_last;
        cnt_d    = cnt_last ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (cnt_last) begin
            idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Leading-zero suppression mask over the display word.
    always_comb begin
        lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (disp_val_q[4*i +: 4] != 4'h0) begin
                    seen = 1'b1;
                end
                lz[i] = !seen;
            end
        end
`endif
    end

    always_comb begin
        nib = 4'h0;
        blk = 1'b1;
        dpl = 1'b0;
        sup = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (32'(idx_q) == i) begin
                nib = disp_val_q[4*i +: 4];
                blk = disp_blank_q[i];
                dpl = disp_dp_q[i];
                sup = lz[i];
            end
        end
        dark    = blk || sup;
        in_dead = (32'(cnt_q) < DEAD_CYCLES);
        // Segments stay driven through dead time; only the anodes are held off.
        seg_d   = dark ? SEG_OFF : (SEG_ACTIVE_LOW ? decode(nib) : ~decode(nib));
        // A suppressed leading zero still shows its decimal point.
        dp_d    = (dpl && !blk) ? ~DP_OFF : DP_OFF;
        an_d    = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((32'(idx_q) == i) && !dark && !in_dead) begin
                an_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            pend_val_q   <= '0;
            pend_blank_q <= '1;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_blank_q <= '1;
            disp_dp_q    <= '0;
            seg          <= SEG_OFF;
            dp           <= DP_OFF;
            an           <= '1;
            digit_idx    <= '0;
            frame_start  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            wrap_q <= boundary;
            if (boundary) begin
                // A load landing on the boundary goes straight to the display.
                if (load) begin
                    disp_val_q   <= value;
                    disp_blank_q <= blank;
                    disp_dp_q    <= dp_in;
                end else if (pend_valid_q) begin
                    disp_val_q   <= pend_val_q;
                    disp_blank_q <= pend_blank_q;
                    disp_dp_q    <= pend_dp_q;
                end
                pend_valid_q <= 1'b0;
            end else if (load) begin
                pend_val_q   <= value;
                pend_blank_q <= blank;
                pend_dp_q    <= dp_in;
                pend_valid_q <= 1'b1;
            end
            seg         <= seg_d;
            dp          <= dp_d;
            an          <= an_d;
            digit_idx   <= idx_q;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1).
// Expected frames are queued as loads are driven and compared cycle by cycle per frame.

module tb_seg7_scan_driver;

    localparam int unsigned N  = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned DC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    seg7_scan_driver #(
        .NUM_DIGITS    (N),
        .SCAN_DIV      (SD),
        .DEAD_CYCLES   (DC),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .blank      (blank),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  d;
    } frame_t;

    frame_t     exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [6:0] seg_tbl[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t mk(logic [15:0] v, logic [3:0] b, logic [3:0] d);
        frame_t f;
        f.v = v;
        f.b = b;
        f.d = d;
        return f;
    endfunction

    function automatic logic lz_dark(frame_t f, int i);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (i == 0) return 1'b0;
        for (int j = i; j < 4; j++) begin
            if (f.v[j*4 +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
`else
        return (i < 0);
`endif
    endfunction

    task automatic drive_load(logic [15:0] v, logic [3:0] b, logic [3:0] d);
        value = v;
        blank = b;
        dp_in = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Waits (bounded) for frame_start, then checks all 16 cycles of one frame.
    task automatic check_frame(string name);
        int     guard = 0;
        frame_t f;
        while (frame_start !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            $display("FAIL %s frame_start: got %b want 1 within 40 cycles", name, frame_start);
            return;
        end
        n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue want a queued frame", name);
            return;
        end
        n_pass++;
        f = exp_q.pop_front();
        for (int k = 0; k < 16; k++) begin
            int         slot = k / 4;
            int         ph   = k % 4;
            logic       dk   = f.b[slot] | lz_dark(f, slot);
            logic [6:0] es   = dk ? 7'h7F : seg_tbl[f.v[slot*4 +: 4]];
            logic       ed   = (f.d[slot] && !f.b[slot]) ? 1'b0 : 1'b1;
            logic [3:0] ea   = 4'hF;
            logic [1:0] ei   = 2'(slot);
            if (!dk && ph >= 1) ea[slot] = 1'b0;
            n_checks++;
            if ({seg, dp, an, digit_idx} !== {es, ed, ea, ei}) begin
                $display("FAIL %s cycle %0d: got seg=%h dp=%b an=%h idx=%0d want seg=%h dp=%b an=%h idx=%0d",
                         name, k, seg, dp, an, digit_idx, es, ed, ea, ei);
            end else begin
                n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int lows = 0;
        rst_n = 1'b0;
        value = '0;
        load  = 1'b0;
        blank = '0;
        dp_in = '0;
        repeat (3) tick();
        n_checks++;
        if ({an, seg, dp, digit_idx, frame_start} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            $display("FAIL reset_state: got an=%h seg=%h dp=%b idx=%0d fs=%b", an, seg, dp,
                     digit_idx, frame_start);
        end else n_pass++;
        rst_n = 1'b1;
        drive_load(16'h1234, 4'h0, 4'h0);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (an != 4'hF) lows++;
        end
        n_checks++;
        if (lows == 0) begin
            $display("FAIL pre_reset_scan: got %0d enabled cycles want >0", lows);
        end else n_pass++;
        // Reset in the middle of a cycle, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({an, seg, dp, digit_idx, frame_start} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            $display("FAIL async_reset: got an=%h seg=%h dp=%b idx=%0d fs=%b", an, seg, dp,
                     digit_idx, frame_start);
        end else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        value = 16'h1A3F;
        blank = 4'h0;
        dp_in = 4'b0100;
        load  = 1'b1;
        exp_q.push_back(mk(16'h1A3F, 4'h0, 4'b0100));
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) load = 1'b0;
            n_checks++;
            if (frame_start !== (k == 17)) begin
                $display("FAIL restart_frame_start cycle %0d: got %b want %b", k, frame_start,
                         (k == 17));
            end else n_pass++;
            if (k <= 16) begin
                n_checks++;
                if (an !== 4'hF) begin
                    $display("FAIL blank_after_reset cycle %0d: got an=%h want F", k, an);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_decode();
        check_frame("decode_1A3F");
    endtask

    task automatic test_last_load_wins();
        exp_q.push_back(mk(16'h1A3F, 4'h0, 4'b0100));
        fork
            check_frame("hold_1A3F");
            begin
                repeat (2) tick();
                drive_load(16'h1234, 4'h0, 4'h0);
                tick();
                exp_q.push_back(mk(16'h5678, 4'h0, 4'b0001));
                drive_load(16'h5678, 4'h0, 4'b0001);
            end
        join
        check_frame("last_load_5678");
    endtask

    task automatic test_boundary_load();
        exp_q.push_back(mk(16'h5678, 4'h0, 4'b0001));
        fork
            check_frame("hold_5678");
            begin
                repeat (14) tick();
                exp_q.push_back(mk(16'hBEEF, 4'h0, 4'h0));
                drive_load(16'hBEEF, 4'h0, 4'h0);
            end
        join
        check_frame("boundary_BEEF");
    endtask

    task automatic test_blanking();
        exp_q.push_back(mk(16'hBEEF, 4'h0, 4'h0));
        fork
            check_frame("hold_BEEF");
            begin
                repeat (2) tick();
                exp_q.push_back(mk(16'h8888, 4'b1010, 4'b0101));
                drive_load(16'h8888, 4'b1010, 4'b0101);
            end
        join
        check_frame("blank_8888");
    endtask

    task automatic test_leading_zero();
        exp_q.push_back(mk(16'h8888, 4'b1010, 4'b0101));
        fork
            check_frame("hold_8888");
            begin
                tick();
                exp_q.push_back(mk(16'h0050, 4'h0, 4'h0));
                drive_load(16'h0050, 4'h0, 4'h0);
            end
        join
        check_frame("lead_0050");
        exp_q.push_back(mk(16'h0050, 4'h0, 4'h0));
        fork
            check_frame("hold_0050");
            begin
                tick();
                exp_q.push_back(mk(16'h0000, 4'h0, 4'h0));
                drive_load(16'h0000, 4'h0, 4'h0);
            end
        join
        check_frame("lead_0000");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_last_load_wins();
        test_boundary_load();
        test_blanking();
        test_leading_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1, "watchdog");
    end

endmodule
